// File: rtl/i2s_frame_scheduler_pkg.sv
// Shared state encoding and frame/burst constants for the I2S frame scheduler.
package i2s_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        LOAD,
        SEND
    } state_t;

    localparam int unsigned FRAME_SLOTS       = 4;
    localparam int unsigned BURST_LEN         = 64;
    localparam int unsigned DEFAULT_SLOT_BITS = 16;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/i2s_frame_scheduler_if.sv
// Source handshake plus serializer-facing slot/control bundle.
interface i2s_frame_scheduler_if
    import i2s_frame_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned SLOT_BITS = DEFAULT_SLOT_BITS
);
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_SRC*SLOT_BITS-1:0] src_data;
    logic [SLOT_BITS-1:0]         frame0;
    logic [SLOT_BITS-1:0]         frame1;
    logic [SLOT_BITS-1:0]         frame2;
    logic [SLOT_BITS-1:0]         frame3;
    logic                         start;
    logic                         option;
    logic                         ser_rst;

    modport master (
        input  src_valid, src_data,
        output src_ready, frame0, frame1, frame2, frame3, start, option, ser_rst
    );

    modport slave (
        output src_valid, src_data,
        input  src_ready, frame0, frame1, frame2, frame3, start, option, ser_rst
    );
endinterface

// File: rtl/i2s_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_SRC);
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2s_frame_scheduler.sv
// Gathers four arbitrated samples into slot registers, then runs one
// 64-cycle serializer burst with the serializer held in reset otherwise.
module i2s_frame_scheduler
    import i2s_frame_scheduler_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned SLOT_BITS      = DEFAULT_SLOT_BITS,
    parameter int unsigned GATHER_TIMEOUT = 32
) (
    input  logic                  bclk,
    input  logic                  rst,
    input  logic                  enable,
    i2s_frame_scheduler_if.master bus,
    output logic                  busy,
    output logic                  underrun
);
    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned TMO_W = (GATHER_TIMEOUT > 1) ? $clog2(GATHER_TIMEOUT) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_LEN);

    state_t               state;
    logic [2:0]           slot;
    logic [2:0]           slot_n;
    logic [TMO_W-1:0]     tmo;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_SRC-1:0]   grant;
    logic                 grant_any;
    logic                 hs;
    logic                 tmo_hit;
    logic                 zero_filled;
    logic                 start_q;
    logic                 option_q;
    logic                 ser_rst_q;
    logic                 busy_q;
    logic                 underrun_q;
    logic [SLOT_BITS-1:0] frame_q [FRAME_SLOTS];

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (bus.src_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign hs            = (state == GATHER) && grant_any;
    assign bus.src_ready = (state == GATHER) ? grant : '0;
    assign slot_n        = slot + {2'b00, hs};
    assign tmo_hit       = (tmo == TMO_W'(GATHER_TIMEOUT - 1));

    assign bus.frame0  = frame_q[0];
    assign bus.frame1  = frame_q[1];
    assign bus.frame2  = frame_q[2];
    assign bus.frame3  = frame_q[3];
    assign bus.start   = start_q;
    assign bus.option  = option_q;
    assign bus.ser_rst = ser_rst_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            slot        <= '0;
            tmo         <= '0;
            cnt         <= '0;
            ptr         <= '0;
            zero_filled <= 1'b0;
            start_q     <= 1'b0;
            option_q    <= 1'b0;
            ser_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
            for (int unsigned i = 0; i < FRAME_SLOTS; i++) frame_q[i] <= '0;
        end else begin
            underrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= GATHER;
                        slot        <= '0;
                        tmo         <= '0;
                        zero_filled <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                GATHER: begin
                    tmo  <= tmo + 1'b1;
                    slot <= slot_n;
                    if (hs) begin
                        frame_q[slot[1:0]] <= bus.src_data[32'(grant_idx) * SLOT_BITS +: SLOT_BITS];
                        ptr                <= IDX_W'(wrap_inc(32'(grant_idx), NUM_SRC));
                    end
                    if (slot_n == 3'(FRAME_SLOTS)) begin
                        state <= LOAD;
                    end else if (tmo_hit) begin
                        // Slots above any same-cycle capture are cleared.
                        for (int unsigned i = 0; i < FRAME_SLOTS; i++)
                            if (3'(i) >= slot_n) frame_q[i] <= '0;
                        zero_filled <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    state      <= SEND;
                    cnt        <= '0;
                    start_q    <= 1'b1;
                    ser_rst_q  <= 1'b0;
                    option_q   <= 1'b0;
                    underrun_q <= zero_filled;
                end
                SEND: begin
                    if (cnt == CNT_W'(BURST_LEN - 1)) begin
                        start_q   <= 1'b0;
                        ser_rst_q <= 1'b1;
                        option_q  <= 1'b0;
                        if (enable) begin
                            state       <= GATHER;
                            slot        <= '0;
                            tmo         <= '0;
                            zero_filled <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt      <= cnt + 1'b1;
                        option_q <= (cnt >= CNT_W'(BURST_LEN / 2 - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed scoreboard bench for i2s_frame_scheduler.
module tb_i2s_frame_scheduler;
    localparam int NSRC = 4;
    localparam int SB   = 16;
    localparam int TMO  = 32;

    typedef struct packed {
        logic [SB-1:0] f0, f1, f2, f3;
        logic          und;
        logic [7:0]    gap_hs;
        logic [7:0]    gap_busy;
    } burst_t;

    logic bclk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    logic busy, underrun;

    i2s_frame_scheduler_if #(.NUM_SRC(NSRC), .SLOT_BITS(SB)) bus ();

    i2s_frame_scheduler #(
        .NUM_SRC        (NSRC),
        .SLOT_BITS      (SB),
        .GATHER_TIMEOUT (TMO)
    ) dut (
        .bclk     (bclk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 bclk = ~bclk;

    int checks = 0, errors = 0;
    int cyc = 0, bursts = 0, hs_cyc = 0, busy_cyc = 0, send_len = 0;
    logic prev_start = 1'b0, prev_busy = 1'b0;
    logic busy_s = 1'b0;
    logic [NSRC-1:0] ready_s = '0;

    logic [SB-1:0] smem [NSRC][8];
    int shead [NSRC];
    int stail [NSRC];
    burst_t bq[$];
    int gq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < NSRC; k++) begin
            bus.src_valid[k] = (shead[k] != stail[k]);
            bus.src_data[k*SB +: SB] = bus.src_valid[k] ? smem[k][shead[k] % 8] : '0;
        end
    endtask

    task automatic push_src(input int k, input logic [SB-1:0] d);
        smem[k][stail[k] % 8] = d;
        stail[k]++;
    endtask

    task automatic expect_burst(input logic [SB-1:0] a, b, c, d, input logic und,
                                input int ghs, input int gbusy);
        burst_t e;
        e.f0 = a; e.f1 = b; e.f2 = c; e.f3 = d;
        e.und = und; e.gap_hs = 8'(ghs); e.gap_busy = 8'(gbusy);
        bq.push_back(e);
    endtask

    // One bclk cycle: sample at negedge, then update sources after the posedge.
    task automatic tick();
        logic [NSRC-1:0] hsv;
        int hs_k;
        burst_t e;
        hs_k = -1;
        @(negedge bclk);
        cyc++;
        busy_s  = busy;
        ready_s = bus.src_ready;
        if (!rst) begin
            prev_start = 1'b0;
            prev_busy  = 1'b0;
            send_len   = 0;
        end else begin
            hsv = bus.src_valid & bus.src_ready;
            if (bus.src_ready != '0) chk("ready_without_valid", bus.src_ready & ~bus.src_valid, 0);
            if (hsv != '0) begin
                chk("grant_onehot", $countones(hsv), 1);
                for (int k = 0; k < NSRC; k++) if (hsv[k]) hs_k = k;
                if (gq.size() == 0) chk("grant_unexpected", hs_k, 255);
                else chk("grant_order", hs_k, gq.pop_front());
                hs_cyc = cyc;
            end
            if (busy && !prev_busy) busy_cyc = cyc;
            if (bus.start && !prev_start) begin
                if (bq.size() == 0) chk("burst_unexpected", 1, 0);
                else begin
                    e = bq.pop_front();
                    chk("frame0", bus.frame0, e.f0);
                    chk("frame1", bus.frame1, e.f1);
                    chk("frame2", bus.frame2, e.f2);
                    chk("frame3", bus.frame3, e.f3);
                    chk("underrun_pulse", underrun, e.und);
                    if (e.gap_hs != 0) chk("load_gap", cyc - hs_cyc, e.gap_hs);
                    if (e.gap_busy != 0) chk("gather_len", cyc - busy_cyc, e.gap_busy);
                end
                chk("send_busy", busy, 1);
                send_len = 0;
                bursts++;
            end else begin
                chk("underrun_quiet", underrun, 0);
            end
            chk("ser_rst_vs_start", bus.ser_rst, !bus.start);
            if (bus.start) begin
                chk("send_ready", bus.src_ready, 0);
                chk("option", bus.option, send_len >= 32);
                send_len++;
            end
            if (!bus.start && prev_start) chk("burst_len", send_len, 64);
            prev_start = bus.start;
            prev_busy  = busy;
        end
        @(posedge bclk);
        #1;
        if (hs_k >= 0) shead[hs_k]++;
        drive_src();
    endtask

    task automatic wait_bursts(input int n, input int budget);
        int target;
        int left;
        target = bursts + n;
        left = budget;
        while (bursts < target && left > 0) begin tick(); left--; end
        chk("wait_burst", bursts, target);
    endtask

    task automatic wait_idle(input int budget);
        int left;
        left = budget;
        while (busy_s !== 1'b0 && left > 0) begin tick(); left--; end
        chk("wait_idle", busy_s, 0);
    endtask

    task automatic quiet_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_ready", ready_s, 0);
            chk("idle_busy", busy_s, 0);
        end
    endtask

    initial begin
        for (int k = 0; k < NSRC; k++) begin shead[k] = 0; stail[k] = 0; end
        drive_src();
        tick(); tick();
        chk("rst_start", bus.start, 0);
        chk("rst_option", bus.option, 0);
        chk("rst_ser_rst", bus.ser_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", bus.src_ready, 0);
        chk("rst_frames", {bus.frame0, bus.frame1, bus.frame2, bus.frame3}, 0);
        rst = 1'b1;
        quiet_cycles(3);

        // Three back-to-back full bursts, enable dropped mid-SEND of the third.
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < NSRC; k++) push_src(k, SB'(32'hA000 + b * 32'h1000 + k));
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < NSRC; k++) gq.push_back(k);
            expect_burst(SB'(32'hA000 + b * 32'h1000), SB'(32'hA001 + b * 32'h1000),
                         SB'(32'hA002 + b * 32'h1000), SB'(32'hA003 + b * 32'h1000),
                         1'b0, 2, (b == 0) ? 5 : 0);
        end
        drive_src();
        enable = 1'b1;
        wait_bursts(3, 400);
        repeat (10) tick();
        enable = 1'b0;
        wait_idle(100);

        // Sources 1 and 3 only: held off while disabled, then alternate.
        push_src(1, 16'h5101); push_src(1, 16'h5102);
        push_src(3, 16'h5301); push_src(3, 16'h5302);
        drive_src();
        quiet_cycles(4);
        gq.push_back(1); gq.push_back(3); gq.push_back(1); gq.push_back(3);
        expect_burst(16'h5101, 16'h5301, 16'h5102, 16'h5302, 1'b0, 2, 5);
        enable = 1'b1;
        wait_bursts(1, 200);
        enable = 1'b0;
        wait_idle(100);

        // Single source supplies all four slots in order.
        push_src(2, 16'h1111); push_src(2, 16'h2222);
        push_src(2, 16'h3333); push_src(2, 16'h4444);
        drive_src();
        for (int i = 0; i < 4; i++) gq.push_back(2);
        expect_burst(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 2, 5);
        enable = 1'b1;
        wait_bursts(1, 200);
        enable = 1'b0;
        wait_idle(100);

        // Timeout: two samples only, pointer wraps from 3 to 0.
        push_src(0, 16'hD000); push_src(1, 16'hD001);
        drive_src();
        gq.push_back(0); gq.push_back(1);
        expect_burst(16'hD000, 16'hD001, 16'h0000, 16'h0000, 1'b1, 0, TMO + 1);
        enable = 1'b1;
        wait_bursts(1, 200);
        enable = 1'b0;
        wait_idle(100);

        // Pointer at 2: grants wrap 2,3,0,1; reset lands mid-SEND.
        for (int k = 0; k < NSRC; k++) push_src(k, SB'(32'hE000 + k));
        drive_src();
        gq.push_back(2); gq.push_back(3); gq.push_back(0); gq.push_back(1);
        expect_burst(16'hE002, 16'hE003, 16'hE000, 16'hE001, 1'b0, 2, 5);
        enable = 1'b1;
        wait_bursts(1, 200);
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        chk("midrst_start", bus.start, 0);
        chk("midrst_ser_rst", bus.ser_rst, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_option", bus.option, 0);
        chk("midrst_ready", bus.src_ready, 0);
        chk("midrst_frames", {bus.frame0, bus.frame1, bus.frame2, bus.frame3}, 0);
        tick();
        enable = 1'b0;
        tick();
        rst = 1'b1;

        // After reset the pointer restarts at 0.
        push_src(1, 16'hF101); push_src(1, 16'hF102);
        push_src(2, 16'hF201); push_src(2, 16'hF202);
        drive_src();
        quiet_cycles(3);
        gq.push_back(1); gq.push_back(2); gq.push_back(1); gq.push_back(2);
        expect_burst(16'hF101, 16'hF201, 16'hF102, 16'hF202, 1'b0, 2, 5);
        enable = 1'b1;
        wait_bursts(1, 200);
        enable = 1'b0;
        wait_idle(100);
        quiet_cycles(2);

        chk("burst_queue_empty", bq.size(), 0);
        chk("grant_queue_empty", gq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
- Sequences the four-slot I2S serializer (frame0..frame3, start, option, rst).
- Collects 16-bit samples from NUM_SRC voice sources through a round-robin arbiter into a 4-slot frame buffer.
- Resets the serializer before each burst, then drives start/option for exactly one 64-bit burst.
- Sits between the voice generators and the serializer, on the bclk domain.

Parameters:
NUM_SRC, 4, number of sample sources (2..8)
SLOT_BITS, 16, bits per slot; must match serializer frame width
GATHER_TIMEOUT, 32, max bclk cycles spent in GATHER before unfilled slots are zero-filled

Ports:
bclk  input  1  bit clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  level; allows new bursts to start
src_valid  input  NUM_SRC  per-source sample valid
src_data  input  NUM_SRC*SLOT_BITS  per-source sample; source k at bits [k*16+:16]
src_ready  output  NUM_SRC  one-hot grant; sample taken on edge where valid&ready
frame0, frame1, frame2, frame3  output  SLOT_BITS each  slot registers to serializer
start  output  1  serializer run enable
option  output  1  lrclk value forwarded to serializer
ser_rst  output  1  active-high synchronous reset to serializer
busy  output  1  high in any state except IDLE
underrun  output  1  one-cycle pulse when a burst is sent with zero-filled slots

Behaviour:
- Reset values: frames 0, start 0, option 0, ser_rst 1, src_ready 0, busy 0, underrun 0, slot 0, rr pointer 0, state IDLE.
- Reset mid-operation: all outputs immediately go to reset values, whatever the state.
- IDLE: ser_rst=1. When enable=1, go to GATHER with slot=0 and timeout counter=0.
- GATHER: ser_rst=1.
  - src_ready is combinational from the registered rr pointer and src_valid. Grant goes to the first valid source at or after the pointer, wrapping mod NUM_SRC.
  - On a handshake: frame[slot] <= granted data, slot++, pointer <= (granted+1) mod NUM_SRC. Maximum one sample per cycle.
  - slot reaching 4 goes to LOAD.
  - Timeout counter increments each GATHER cycle. When it reaches GATHER_TIMEOUT-1 without 4 slots filled:
    - remaining slots (slot..3) are written to 0;
    - underrun pulses in the first SEND cycle;
    - go to LOAD.
  - A handshake on that same cycle is still captured into its slot.
- LOAD: exactly one cycle; ser_rst=1, start=0, src_ready=0. Frames are stable from this cycle until SEND ends.
- SEND:
  - ser_rst=0, start=1 for exactly 64 cycles, counted 0..63.
  - option=0 for counts 0..31 and 1 for 32..63 (slots 0–1 left, slots 2–3 right).
  - src_ready=0 throughout.
  - After count 63: start=0, ser_rst=1. Go to GATHER (slot=0, timeout=0) if enable=1, else IDLE.
- enable falling during GATHER, LOAD or SEND: the current burst completes, then the block returns to IDLE. A burst is never truncated.
- Minimum burst period: 4 GATHER + 1 LOAD + 64 SEND = 69 cycles.

Decomposition:
- Shared package:
  - state enum {IDLE, GATHER, LOAD, SEND};
  - FRAME_SLOTS=4; BURST_LEN=64; SLOT_BITS default.
- One sub-module: rr_arbiter.
  - Inputs: NUM_SRC requests, pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Reset: assert rst=0 mid-SEND → same cycle start=0, ser_rst=1, frames=0, busy=0. Release → IDLE, no activity until enable.
- All 4 sources valid with data 0xA000+k, enable=1:
  - grants 0,1,2,3 on consecutive cycles; frames = A000, A001, A002, A003;
  - one LOAD cycle, then start high 64 cycles, option 0 ×32 then 1 ×32;
  - underrun stays 0.
- Only source 2 valid, presenting 0x1111, 0x2222, 0x3333, 0x4444 → frame0..3 hold those values in order; pointer wraps 3→0→…→2 correctly.
- Fairness, all valid for 3 consecutive bursts → grant order 0,1,2,3 | 0,1,2,3 | … with no source starved. With sources 1 and 3 only → 1,3,1,3.
- Timeout (GATHER_TIMEOUT=32): only 2 samples by cycle 31 → frame2=frame3=0, underrun one pulse at first SEND cycle, burst sent normally.
- enable dropped at SEND count 10 → start remains high through count 63, then IDLE, src_ready stays 0, busy falls.
